// File: rtl/ascon_round_ctrl.sv
// Round sequencer for the Ascon permutation: loads the 320-bit state, iterates an external
// single-round datapath for 1..NR_MAX rounds, then writes the result back with a one-cycle strobe.
// Word layout of every 320-bit bus: x0 in [63:0], x1 in [127:64], ..., x4 in [319:256].
module ascon_round_ctrl #(
  parameter int NR_MAX = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  output logic [319:0] round_state_o,
  output logic [7:0]   round_const_o,
  input  logic [319:0] round_state_i,
  output logic [319:0] state_o,
  output logic         update_state_o,
  output logic         finished_o,
  output logic         busy_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;
  localparam logic [1:0] S_WAIT_LOW = 2'd3;

  localparam logic [3:0] NR_CNT   = 4'(NR_MAX);
  localparam logic [3:0] RND_LAST = 4'(NR_MAX - 1);

  logic [1:0]   fsm;
  logic [319:0] work;
  logic [3:0]   rnd;

  // Out-of-range requests (0 or above NR_MAX) fall back to the full permutation.
  function automatic logic [3:0] eff_rounds(input logic [3:0] r);
    if (r == 4'd0 || r > NR_CNT)
      return NR_CNT;
    else
      return r;
  endfunction

  // Shorter runs start part-way into the constant schedule so the last round is always RND_LAST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm  <= S_IDLE;
      work <= '0;
      rnd  <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (start_i) begin
            work <= state_i;
            rnd  <= NR_CNT - eff_rounds(rounds_i);
            fsm  <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            fsm <= S_WAIT_LOW;
          end else begin
            work <= round_state_i;
            rnd  <= rnd + 4'd1;
            if (rnd == RND_LAST)
              fsm <= S_DONE;
          end
        end
        S_DONE: fsm <= S_WAIT_LOW;
        S_WAIT_LOW: begin
          if (!start_i)
            fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign round_state_o  = work;
  assign state_o        = work;
  assign round_const_o  = (fsm == S_RUN) ? {4'hF - rnd, rnd} : 8'h00;
  assign update_state_o = (fsm == S_DONE);
  assign finished_o     = (fsm == S_DONE);
  assign busy_o         = (fsm == S_RUN) || (fsm == S_DONE);

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Directed bench for ascon_round_ctrl with an XOR-constant-into-x0 round stub.
module tb_ascon_round_ctrl;

  logic         clk;
  logic         rst_i;
  logic         start_i;
  logic         abort_i;
  logic [3:0]   rounds_i;
  logic [319:0] state_i;
  logic [319:0] round_state_o;
  logic [7:0]   round_const_o;
  logic [319:0] round_state_i;
  logic [319:0] state_o;
  logic         update_state_o;
  logic         finished_o;
  logic         busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  ascon_round_ctrl #(.NR_MAX(12)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .rounds_i       (rounds_i),
    .state_i        (state_i),
    .round_state_o  (round_state_o),
    .round_const_o  (round_const_o),
    .round_state_i  (round_state_i),
    .state_o        (state_o),
    .update_state_o (update_state_o),
    .finished_o     (finished_o),
    .busy_o         (busy_o)
  );

  // Round stub: x0 ^= rc, x1..x4 pass through.
  always_comb begin
    round_state_i        = round_state_o;
    round_state_i[63:0]  = round_state_o[63:0] ^ {56'd0, round_const_o};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full run from IDLE with start dropped right after acceptance; returns in IDLE.
  task automatic run_check(input logic [3:0] r_req, input int nr,
                           input logic [319:0] init, input string tag);
    logic [319:0] exp;
    int base;
    base     = 12 - nr;
    rounds_i = r_req;
    state_i  = init;
    start_i  = 1'b1;
    tick;
    start_i  = 1'b0;
    rounds_i = 4'd3;
    state_i  = ~init;
    exp      = init;
    for (int k = 0; k < nr; k++) begin
      chk({tag, "_busy"}, busy_o, 1'b1);
      chk({tag, "_rc"}, round_const_o, rc_tab[base + k]);
      chk({tag, "_fin_early"}, finished_o, 1'b0);
      chk({tag, "_state_run"}, state_o, exp);
      exp[63:0] = exp[63:0] ^ {56'd0, rc_tab[base + k]};
      tick;
    end
    chk({tag, "_finished"}, finished_o, 1'b1);
    chk({tag, "_update"}, update_state_o, 1'b1);
    chk({tag, "_rc_done"}, round_const_o, 8'h00);
    chk({tag, "_result"}, state_o, exp);
    tick;
    chk({tag, "_fin_after"}, finished_o, 1'b0);
    chk({tag, "_busy_after"}, busy_o, 1'b0);
    tick;
  endtask

  logic [319:0] init_a;
  logic [319:0] init_b;
  logic [319:0] exp_v;
  int pulses;
  int first;

  initial begin
    init_a = {64'h4444_4444_DDDD_0004, 64'h3333_3333_CCCC_0003, 64'h2222_2222_BBBB_0002,
              64'h1111_1111_AAAA_0001, 64'h0000_0000_0000_0000};
    init_b = {64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978, 64'hA5A5_5A5A_C3C3_3C3C,
              64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF};
    rst_i    = 1'b1;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    rounds_i = 4'd0;
    state_i  = init_a;
    tick;
    tick;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_fin", finished_o, 1'b0);
    chk("rst_upd", update_state_o, 1'b0);
    chk("rst_rc", round_const_o, 8'h00);
    chk("rst_state", state_o, '0);
    rst_i = 1'b0;
    tick;
    chk("idle_busy", busy_o, 1'b0);

    run_check(4'd12, 12, init_a, "r12");
    run_check(4'd6, 6, init_b, "r6");
    run_check(4'd0, 12, init_b, "r0");
    run_check(4'd15, 12, init_a, "r15");
    run_check(4'd1, 1, init_b, "r1");

    // Start held high for 40 cycles must produce a single run.
    rounds_i = 4'd6;
    state_i  = init_a;
    start_i  = 1'b1;
    pulses   = 0;
    first    = -1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (finished_o === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    chk("held_pulses", pulses, 1);
    chk("held_latency", first, 7);
    chk("held_busy", busy_o, 1'b0);
    start_i = 1'b0;
    tick;
    start_i = 1'b1;
    tick;
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      if (finished_o === 1'b1 && first < 0) first = c;
      tick;
    end
    chk("restart_latency", first, 7);
    start_i = 1'b0;
    tick;
    tick;

    // Abort sampled at the end of the 3rd RUN cycle: two rounds kept, no write-back.
    rounds_i = 4'd12;
    state_i  = init_b;
    start_i  = 1'b1;
    tick;
    start_i  = 1'b0;
    tick;
    tick;
    abort_i  = 1'b1;
    tick;
    abort_i  = 1'b0;
    exp_v    = init_b;
    exp_v[63:0] = exp_v[63:0] ^ 64'h11;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_rc", round_const_o, 8'h00);
    chk("abort_fin", finished_o, 1'b0);
    chk("abort_upd", update_state_o, 1'b0);
    chk("abort_state", state_o, exp_v);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick;
      if (finished_o === 1'b1 || update_state_o === 1'b1) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_state_hold", state_o, exp_v);

    // Reset sampled at the end of the 5th RUN cycle.
    rounds_i = 4'd12;
    state_i  = init_a;
    start_i  = 1'b1;
    tick;
    start_i  = 1'b0;
    tick;
    tick;
    tick;
    tick;
    rst_i    = 1'b1;
    tick;
    rst_i    = 1'b0;
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_fin", finished_o, 1'b0);
    chk("mrst_upd", update_state_o, 1'b0);
    chk("mrst_rc", round_const_o, 8'h00);
    chk("mrst_state", state_o, '0);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick;
      if (finished_o === 1'b1) pulses++;
    end
    chk("mrst_no_pulse", pulses, 0);
    run_check(4'd12, 12, init_b, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
